// File: rtl/bram_sdp_pkg.sv
// bram_sdp_pkg: shared constants for the simple dual-port block RAM.
//
// BRAM_SDP_RD_LATENCY is the number of clock edges from sampling rd_en to
// valid rd_data. Parent blocks use it to size their valid-delay pipelines.
// It follows the optional macro BRAM_SDP_OUT_REG_EN:
//   undefined -> 1 (array read register only)
//   defined   -> 2 (array read register + output pipeline register)
package bram_sdp_pkg;

`ifdef BRAM_SDP_OUT_REG_EN
    localparam int unsigned BRAM_SDP_RD_LATENCY = 2;
`else
    localparam int unsigned BRAM_SDP_RD_LATENCY = 1;
`endif

endpackage

// File: rtl/bram_sdp_out_reg.sv
// bram_sdp_out_reg: optional output pipeline stage behind the RAM read register.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears q
//   load  - load enable (the read strobe delayed by one cycle)
//   d     - data from the array read register
//   q     - registered output; holds while load is low
module bram_sdp_out_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port block RAM, one write port, one read port, one clock.
//
// Line/feature-map buffer: the writer fills words sequentially, the reader
// fetches them back. Read data is registered. Write-first on a same-address
// collision. Out-of-range writes are dropped; out-of-range reads return zero.
// Array contents are not touched by rst; only the read-side registers clear.
//
// Optional feature (macro BRAM_SDP_OUT_REG_EN): adds an output pipeline
// register, raising read latency from 1 to 2. RD_LATENCY reports the value.
//
// Ports:
//   clk     - sole clock, rising edge
//   rst     - synchronous active-high reset; blocks reads and writes that cycle
//   wr_en   - write strobe
//   rd_en   - read strobe
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - registered read data (holds when no read is issued)
module bram_sdp
    import bram_sdp_pkg::*;
#(
    parameter int unsigned RAM_WIDTH  = 8,
    parameter int unsigned RAM_DEPTH  = 1,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [RAM_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [RAM_WIDTH-1:0]  rd_data
);

    localparam int unsigned RD_LATENCY = BRAM_SDP_RD_LATENCY;

    // One extra bit so RAM_DEPTH itself (up to 2**ADDR_WIDTH) is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    // Zero-initialised at configuration time; rst never clears it.
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH] = '{default: '0};

    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 collide;
    logic [RAM_WIDTH-1:0] rd_q;

    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
        collide     = wr_en && (wr_addr == rd_addr);
    end

    // Write port: kept free of reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register. A same-cycle write to the read address forwards the new
    // word (write-first). Out-of-range reads load zero rather than aliasing.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_en) begin
            if (!rd_in_range) begin
                rd_q <= '0;
            end else if (collide) begin
                rd_q <= wr_data;
            end else begin
                rd_q <= mem[rd_addr];
            end
        end
    end

`ifdef BRAM_SDP_OUT_REG_EN
    // Read strobe delayed to line up with data in rd_q.
    logic rd_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q <= 1'b0;
        end else begin
            rd_en_q <= rd_en;
        end
    end

    bram_sdp_out_reg #(
        .WIDTH(RAM_WIDTH)
    ) u_out_reg (
        .clk  (clk),
        .rst  (rst),
        .load (rd_en_q),
        .d    (rd_q),
        .q    (rd_data)
    );
`else
    assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_bram_sdp.sv
// tb_bram_sdp: self-checking bench for bram_sdp (RAM_WIDTH=8, RAM_DEPTH=9,
// ADDR_WIDTH=4). Directed scenarios followed by a randomized phase, all
// compared against a behavioural model of the memory and read pipeline.
module tb_bram_sdp;

    localparam int W     = 8;
    localparam int DEPTH = 9;
    localparam int AW    = 4;
`ifdef BRAM_SDP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;

    int checks = 0;
    int errors = 0;

    // Reference model: word array plus a history of read results.
    logic [W-1:0] model_mem [DEPTH];
    logic [W-1:0] read_result;   // value produced by the most recent read
    logic [W-1:0] exp_out;       // value expected at rd_data
    logic         prev_read;     // a read was issued on the previous edge

    bram_sdp #(
        .RAM_WIDTH  (W),
        .RAM_DEPTH  (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] expected);
        checks++;
        assert (rd_data === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, rd_data, expected);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, compare #1 later.
    task automatic cycle(input logic r, input logic we, input int wa, input logic [W-1:0] wd,
                         input logic re, input int ra);
        logic [W-1:0] fetched;
        @(negedge clk);
        rst     = r;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        rd_en   = re;
        rd_addr = AW'(ra);
        @(posedge clk);
        if (r) begin
            read_result = '0;
            exp_out     = '0;
            prev_read   = 1'b0;
        end else begin
            if (re) begin
                if (ra >= DEPTH)               fetched = '0;
                else if (we && wa == ra)       fetched = wd;
                else                           fetched = model_mem[ra];
            end
            if (LAT == 1) begin
                if (re) exp_out = fetched;
            end else begin
                if (prev_read) exp_out = read_result;
            end
            if (re) read_result = fetched;
            prev_read = re;
            if (we && wa < DEPTH) model_mem[wa] = wd;
        end
        #1;
        check("model", exp_out);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 15, 8'h00, 1'b0, 15);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        read_result = '0;
        exp_out     = '0;
        prev_read   = 1'b0;

        // Reset
        cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 0);
        cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 0);
        check("reset", 8'h00);

        // 1. Sequential fill and back-to-back readback
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b1, a, 8'h10 + 8'(a), 1'b0, 15);
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 1'b0, 15, 8'h00, 1'b1, a);
            if (a >= LAT - 1) check("seq_read", 8'h10 + 8'(a - (LAT - 1)));
        end
        idle(LAT - 1);
        check("seq_last", 8'h18);

        // 2. Hold and out-of-range
        cycle(1'b0, 1'b0, 15, 8'h00, 1'b1, 3);
        idle(LAT - 1);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            check("hold", 8'h13);
        end
        cycle(1'b0, 1'b1, 15, 8'hAA, 1'b0, 15);
        check("hold_oor_wr", 8'h13);
        cycle(1'b0, 1'b0, 15, 8'h00, 1'b1, 15);
        idle(LAT - 1);
        check("oor_read", 8'h00);
        cycle(1'b0, 1'b0, 15, 8'h00, 1'b1, 0);
        idle(LAT - 1);
        check("no_alias", 8'h10);

        // 3. Collision: write-first
        cycle(1'b0, 1'b1, 4, 8'h5C, 1'b1, 4);
        idle(LAT - 1);
        check("collision", 8'h5C);
        cycle(1'b0, 1'b0, 15, 8'h00, 1'b1, 4);
        idle(LAT - 1);
        check("collision_mem", 8'h5C);

        // 4. Reset mid-operation with a suppressed write
        cycle(1'b0, 1'b0, 15, 8'h00, 1'b1, 7);
        idle(LAT - 1);
        check("pre_reset", 8'h17);
        cycle(1'b1, 1'b1, 2, 8'hFF, 1'b1, 7);
        check("mid_reset", 8'h00);
        cycle(1'b0, 1'b0, 15, 8'h00, 1'b1, 2);
        idle(LAT - 1);
        check("retained", 8'h12);

        // 5. Simultaneous independent access
        cycle(1'b0, 1'b1, 1, 8'h77, 1'b1, 8);
        idle(LAT - 1);
        check("indep_read", 8'h18);
        cycle(1'b0, 1'b0, 15, 8'h00, 1'b1, 1);
        idle(LAT - 1);
        check("indep_write", 8'h77);

        // Randomized traffic, addresses over the full 4-bit range
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 31) == 0), 1'($urandom), int'($urandom_range(0, 15)),
                  8'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
